// File: rtl/beat_packer_pkg.sv
// Shared handshake definitions for the beat packer: FSM encoding and default geometry.
package beat_packer_pkg;

  localparam int DEF_L = 8;
  localparam int DEF_N = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ACC   = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

endpackage

// File: rtl/beat_packer_lane_select.sv
// Binary-to-one-hot decoder turning the lane counter into a per-lane write enable.
module lane_select #(
  parameter int N  = 4,
  parameter int CW = $clog2(N)
) (
  input  logic [CW-1:0] sel,
  output logic [N-1:0]  lane_en
);

  always_comb begin
    lane_en = '0;
    for (int i = 0; i < N; i++) begin
      lane_en[i] = (sel == CW'(i));
    end
  end

endmodule

// File: rtl/beat_packer.sv
// Packs narrow upstream beats into an N-lane word with a per-lane keep mask.
module beat_packer
  import beat_packer_pkg::*;
#(
  parameter int L = DEF_L,
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_f,
  input  logic [L-1:0]   data_f,
  input  logic           last_f,
  output logic           ready_f,
  output logic           valid_b,
  output logic [N*L-1:0] data_b,
  output logic [N-1:0]   keep_b,
  input  logic           ready_b
);

  localparam int CW = $clog2(N);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  lane_en;
  logic          beat_acc;
  logic          word_acc;
  logic          fresh;
  logic          closes;

  assign ready_f  = !valid_b || ready_b;
  assign beat_acc = valid_f && ready_f;
  assign word_acc = valid_b && ready_b;
  // Any beat taken outside ACC starts a new word, so untouched lanes are zeroed.
  assign fresh    = (state != ST_ACC);
  assign closes   = last_f || (cnt == CW'(N - 1));

  lane_select #(.N(N), .CW(CW)) u_lane_select (
    .sel    (cnt),
    .lane_en(lane_en)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_EMPTY;
      cnt     <= '0;
      valid_b <= 1'b0;
      data_b  <= '0;
      keep_b  <= '0;
    end else if (beat_acc) begin
      for (int i = 0; i < N; i++) begin
        if (lane_en[i]) begin
          data_b[i*L +: L] <= data_f;
        end else if (fresh) begin
          data_b[i*L +: L] <= '0;
        end
      end
      keep_b <= fresh ? lane_en : (keep_b | lane_en);
      if (closes) begin
        state   <= ST_OUT;
        valid_b <= 1'b1;
        cnt     <= '0;
      end else begin
        state   <= ST_ACC;
        valid_b <= 1'b0;
        cnt     <= cnt + CW'(1);
      end
    end else if (word_acc) begin
      state   <= ST_EMPTY;
      valid_b <= 1'b0;
      keep_b  <= '0;
      data_b  <= '0;
    end
  end

endmodule

// File: tb/tb_beat_packer.sv
// Scoreboard bench for beat_packer: directed words plus a long random handshake run.
module tb_beat_packer;

  localparam int L = 8;
  localparam int N = 4;

  typedef struct packed {
    logic [N*L-1:0] data;
    logic [N-1:0]   keep;
  } word_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid_f;
  logic [L-1:0]   data_f;
  logic           last_f;
  logic           ready_f;
  logic           valid_b;
  logic [N*L-1:0] data_b;
  logic [N-1:0]   keep_b;
  logic           ready_b;

  int    total = 0;
  int    bad   = 0;
  word_t exp_q[$];

  bit             model_en = 1'b0;
  logic [N*L-1:0] m_data;
  logic [N-1:0]   m_keep;
  int             m_cnt = 0;

  beat_packer #(.L(L), .N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .valid_f(valid_f),
    .data_f (data_f),
    .last_f (last_f),
    .ready_f(ready_f),
    .valid_b(valid_b),
    .data_b (data_b),
    .keep_b (keep_b),
    .ready_b(ready_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [N*L-1:0] d, input logic [N-1:0] k);
    word_t w;
    w.data = d;
    w.keep = k;
    exp_q.push_back(w);
  endtask

  task automatic model_accept(input logic [L-1:0] d, input logic l);
    if (m_cnt == 0) begin
      m_data = '0;
      m_keep = '0;
    end
    m_data[m_cnt*L +: L] = d;
    m_keep[m_cnt]        = 1'b1;
    m_cnt++;
    if (l || m_cnt == N) begin
      push_word(m_data, m_keep);
      m_cnt = 0;
    end
  endtask

  // One cycle of stimulus; acc reports whether the beat is taken at the next edge.
  task automatic step(input logic v, input logic [L-1:0] d, input logic l, input logic rb,
                      output logic acc);
    @(posedge clk);
    #1;
    valid_f = v;
    data_f  = d;
    last_f  = l;
    ready_b = rb;
    @(negedge clk);
    acc = valid_f && ready_f;
    if (acc && model_en) model_accept(d, l);
  endtask

  task automatic send(input logic [L-1:0] d, input logic l, input logic rb);
    logic acc;
    int   n;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      step(1'b1, d, l, rb, acc);
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: beat 0x%0h not accepted within %0d cycles", d, n);
    end
  endtask

  task automatic idle(input int cycles, input logic rb);
    logic acc;
    for (int i = 0; i < cycles; i++) step(1'b0, '0, 1'b0, rb, acc);
  endtask

  // Monitor: every word handed downstream is compared against the queue head.
  always @(negedge clk) begin
    if (rst && valid_b && ready_b) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got data 0x%0h keep 0x%0h with nothing expected",
                 data_b, keep_b);
      end else begin
        word_t w;
        w = exp_q.pop_front();
        check("word_data", 64'(data_b), 64'(w.data));
        check("word_keep", 64'(keep_b), 64'(w.keep));
      end
    end
  end

  initial begin
    logic acc;
    int   stalls;
    int   beats;
    logic v, l, rb;
    logic [L-1:0] d;

    rst     = 1'b0;
    valid_f = 1'b0;
    data_f  = '0;
    last_f  = 1'b0;
    ready_b = 1'b0;
    #12;
    check("reset_valid_b", 64'(valid_b), 64'd0);
    check("reset_keep_b", 64'(keep_b), 64'd0);
    check("reset_data_b", 64'(data_b), 64'd0);
    check("reset_ready_f", 64'(ready_f), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    // Full word, then latency check one cycle after the fourth accept.
    push_word(32'h44332211, 4'hF);
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    send(8'h33, 1'b0, 1'b1);
    send(8'h44, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, acc);
    check("full_word_latency", 64'(valid_b), 64'd1);
    idle(2, 1'b1);

    // Early close with last_f; last_f while idle must be ignored.
    push_word(32'h0000BBAA, 4'h3);
    step(1'b0, 8'h99, 1'b1, 1'b1, acc);
    send(8'hAA, 1'b0, 1'b1);
    send(8'hBB, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Backpressure: word must hold while ready_b is low.
    push_word(32'h04030201, 4'hF);
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    send(8'h04, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, acc);
      check("stall_ready_f", 64'(ready_f), 64'd0);
      check("stall_valid_b", 64'(valid_b), 64'd1);
      check("stall_data_b", 64'(data_b), 64'h04030201);
      check("stall_keep_b", 64'(keep_b), 64'hF);
    end
    step(1'b1, 8'h55, 1'b0, 1'b1, acc);
    check("handoff_accept", 64'(acc), 64'd1);
    step(1'b0, '0, 1'b0, 1'b1, acc);
    check("fresh_valid_b", 64'(valid_b), 64'd0);
    check("fresh_keep_b", 64'(keep_b), 64'h1);
    check("fresh_data_b", 64'(data_b), 64'h00000055);
    push_word(32'h00006655, 4'h3);
    send(8'h66, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Twelve back-to-back beats must never stall.
    push_word(32'h04030201, 4'hF);
    push_word(32'h08070605, 4'hF);
    push_word(32'h0C0B0A09, 4'hF);
    stalls = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b1, acc);
      if (!acc) stalls++;
    end
    check("stream_stalls", 64'(stalls), 64'd0);
    idle(3, 1'b1);

    // Reset in the middle of a partial word.
    send(8'hE1, 1'b0, 1'b1);
    send(8'hE2, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, acc);
    check("partial_keep_b", 64'(keep_b), 64'h3);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_valid_b", 64'(valid_b), 64'd0);
    check("midrst_keep_b", 64'(keep_b), 64'd0);
    check("midrst_data_b", 64'(data_b), 64'd0);
    check("midrst_ready_f", 64'(ready_f), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    push_word(32'h04030201, 4'hF);
    send(8'h01, 1'b0, 1'b1);
    send(8'h02, 1'b0, 1'b1);
    send(8'h03, 1'b0, 1'b1);
    send(8'h04, 1'b0, 1'b1);
    idle(2, 1'b1);
    check("directed_drained", 64'(exp_q.size()), 64'd0);

    // Random handshake run against the packing reference.
    model_en = 1'b1;
    m_cnt    = 0;
    beats    = 0;
    while (beats < 10000) begin
      v  = ($urandom_range(0, 1) == 1);
      d  = 8'($urandom);
      l  = ($urandom_range(0, 7) == 0);
      rb = ($urandom_range(0, 3) != 0);
      step(v, d, l, rb, acc);
      if (acc) beats++;
    end
    send(8'h5A, 1'b1, 1'b1);
    idle(4, 1'b1);
    check("random_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/beat_packer.md
BEAT_PACKER -- requirements
Module: beat_packer

Interface
REQ-001 SHALL have parameter L, default 8, narrow beat width in bits.
REQ-002 SHALL have parameter N, default 4, beats per packed word; legal range 2..16.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port valid_f  input  1  upstream beat valid.
REQ-006 SHALL have port data_f  input  L  upstream beat data.
REQ-007 SHALL have port last_f  input  1  upstream beat closes the current word early.
REQ-008 SHALL have port ready_f  output  1  packer accepts a beat this cycle.
REQ-009 SHALL have port valid_b  output  1  packed word valid, registered.
REQ-010 SHALL have port data_b  output  N*L  packed word, registered.
REQ-011 SHALL have port keep_b  output  N  per-lane filled mask, registered.
REQ-012 SHALL have port ready_b  input  1  downstream accepts the word (downstream is the backward skid stage).

Function
REQ-013 SHALL accept an upstream beat on any edge where valid_f && ready_f, and a word on any edge where valid_b && ready_b.
REQ-014 SHALL drive ready_f = !valid_b || ready_b, combinationally.
REQ-015 SHALL hold a lane counter cnt, width clog2(N), that counts accepted beats in the word being filled.
REQ-016 SHALL write beat k (k = cnt at acceptance) into data_b[k*L +: L] and set keep_b[k]; lane 0 is the first beat.
REQ-017 SHALL run a 3-state FSM: EMPTY (cnt=0, valid_b=0), ACC (0<cnt<N, valid_b=0), OUT (valid_b=1).
REQ-018 SHALL move EMPTY->ACC on an accepted beat with last_f=0 and N>1 lanes remaining.
REQ-019 SHALL move EMPTY/ACC->OUT on an accepted beat that fills lane N-1 or carries last_f=1, and reset cnt to 0.
REQ-020 SHALL in OUT hold data_b, keep_b and valid_b stable until the word is accepted (no output change while valid_b && !ready_b).
REQ-021 SHALL, when the word is accepted in OUT with no beat accepted, clear valid_b, clear keep_b, and go to EMPTY.
REQ-022 SHALL, when the word is accepted and a beat is accepted in the same cycle, place that beat in lane 0 of a fresh word, set keep_b to one-hot lane 0, and go to ACC, or stay in OUT if last_f=1 or N beats are complete.
REQ-023 SHALL zero the lanes not written in the current word; after acceptance, stale data SHALL NOT appear in unfilled lanes.
REQ-024 SHALL treat last_f as ignored when valid_f=0.
REQ-025 SHALL produce a full word one cycle after the acceptance of beat N-1 (valid_b high on the following cycle).
REQ-026 SHALL sustain one beat per cycle with ready_b held high; there SHALL be no bubble between words.

Reset
REQ-027 SHALL, while rst=0, asynchronously force valid_b=0, data_b=0, keep_b=0, cnt=0, FSM=EMPTY.
REQ-028 SHALL discard any partially filled word on reset mid-operation; ready_f SHALL read 1 during and after reset.
REQ-029 SHALL release reset synchronously into EMPTY; the first accepted beat after release lands in lane 0.

Structure
REQ-030 SHALL place the FSM state encoding (EMPTY/ACC/OUT) and default L/N constants in the shared handshake package.
REQ-031 SHALL use one sub-module, lane_select, a binary-to-one-hot decoder of cnt producing the N-bit lane write enable.
REQ-032 SHALL be pure sequential RTL with no latches.

Verification
REQ-033 SHALL cover: L=8, N=4, ready_b=1, beats 11,22,33,44 -> one word data_b=0x44332211, keep_b=0xF, valid_b high 1 cycle after the 4th accept.
REQ-034 SHALL cover: beats AA,BB with last_f on BB -> data_b=0x0000BBAA, keep_b=0x3.
REQ-035 SHALL cover: word valid, ready_b=0 for 5 cycles -> ready_f=0, data_b/keep_b stable; ready_b=1 with beat 55 -> next word lane0=0x55, keep_b=0x1.
REQ-036 SHALL cover: continuous 12 beats 01..0C with ready_b=1 -> 3 back-to-back words 0x04030201, 0x08070605, 0x0C0B0A09, with no idle cycle between words.
REQ-037 SHALL cover: reset asserted after 2 beats -> valid_b=0, keep_b=0 immediately; the next beats 01..04 -> 0x04030201.
REQ-038 SHALL cover: random valid_f/ready_b toggling over 10k beats -> scoreboard matches packed reference, no lost or duplicated beats.
